// File: rtl/lc3b_wb_buffer_pkg.sv
// Shared types and default sizes for the L1->L2 write-back buffer.
package lc3b_wb_buffer_pkg;

  localparam int unsigned LC3B_LINE_W   = 128;
  localparam int unsigned LC3B_ADDR_W   = 12;
  localparam int unsigned LC3B_WB_DEPTH = 4;

  typedef logic [LC3B_ADDR_W-1:0] lc3b_line_addr;

  typedef enum logic {
    WB_IDLE  = 1'b0,
    WB_WRITE = 1'b1
  } lc3b_wb_state;

endpackage

// File: rtl/lc3b_wb_buffer_if.sv
// Eviction, lookup, L2 write and status signals of the write-back buffer.
// slave = the buffer itself; master = the L1/L2 side driving it.
interface lc3b_wb_buffer_if
  import lc3b_wb_buffer_pkg::*;
#(
  parameter int unsigned LINE_W = LC3B_LINE_W,
  parameter int unsigned ADDR_W = LC3B_ADDR_W,
  parameter int unsigned DEPTH  = LC3B_WB_DEPTH
) ();

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic              evict_valid;
  logic [ADDR_W-1:0] evict_addr;
  logic [LINE_W-1:0] evict_data;
  logic              evict_ready;
  logic [ADDR_W-1:0] lookup_addr;
  logic              lookup_hit;
  logic [LINE_W-1:0] lookup_data;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_addr;
  logic [LINE_W-1:0] l2_wdata;
  logic              l2_resp;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;

  modport master (
    output evict_valid, evict_addr, evict_data, lookup_addr, l2_resp,
    input  evict_ready, lookup_hit, lookup_data, l2_write, l2_addr, l2_wdata,
           count, full, empty
  );

  modport slave (
    input  evict_valid, evict_addr, evict_data, lookup_addr, l2_resp,
    output evict_ready, lookup_hit, lookup_data, l2_write, l2_addr, l2_wdata,
           count, full, empty
  );

endinterface

// File: rtl/lc3b_wb_cam.sv
// Per-entry address comparators with youngest-match select, shared by the
// lookup port and the coalesce port (which can exclude the in-flight head).
module lc3b_wb_cam
  import lc3b_wb_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = LC3B_WB_DEPTH,
  parameter int unsigned ADDR_W = LC3B_ADDR_W
) (
  input  logic [DEPTH-1:0]         i_valid,
  input  logic [ADDR_W-1:0]        i_addr [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] i_head,
  input  logic [ADDR_W-1:0]        i_lookup_addr,
  output logic                     o_lookup_hit,
  output logic [$clog2(DEPTH)-1:0] o_lookup_idx,
  input  logic [ADDR_W-1:0]        i_coal_addr,
  input  logic                     i_coal_mask_head,
  output logic                     o_coal_hit,
  output logic [$clog2(DEPTH)-1:0] o_coal_idx
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] w_idx;

  // Walk oldest to youngest from the head; a later match overrides an earlier one.
  always_comb begin
    o_lookup_hit = 1'b0;
    o_lookup_idx = '0;
    o_coal_hit   = 1'b0;
    o_coal_idx   = '0;
    w_idx        = i_head;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = i_head + PW'(k);
      if (i_valid[w_idx] && (i_addr[w_idx] == i_lookup_addr)) begin
        o_lookup_hit = 1'b1;
        o_lookup_idx = w_idx;
      end
      if (i_valid[w_idx] && (i_addr[w_idx] == i_coal_addr) && !(i_coal_mask_head && (k == 0))) begin
        o_coal_hit = 1'b1;
        o_coal_idx = w_idx;
      end
    end
  end

endmodule

// File: rtl/lc3b_wb_buffer.sv
// DEPTH-entry write-back FIFO between L1 and L2 with same-cycle lookup.
// Optional write coalescing into queued lines: define LC3B_WB_COALESCE_EN.
module lc3b_wb_buffer
  import lc3b_wb_buffer_pkg::*;
#(
  parameter int unsigned LINE_W = LC3B_LINE_W,
  parameter int unsigned ADDR_W = LC3B_ADDR_W,
  parameter int unsigned DEPTH  = LC3B_WB_DEPTH
) (
  input logic               clk,
  input logic               rst_n,
  lc3b_wb_buffer_if.slave   bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [LINE_W-1:0] r_data [DEPTH];
  logic [PW-1:0]     r_head, r_tail;
  logic [CW-1:0]     r_count;
  lc3b_wb_state      r_state;

  lc3b_wb_state      w_state_d;
  logic [CW-1:0]     w_count_d;
  logic              w_full, w_ready, w_push_acc, w_alloc, w_pop, w_coal_match, w_coal_wr;
  logic              w_lookup_hit, w_coal_hit;
  logic [PW-1:0]     w_lookup_idx, w_coal_idx;

  lc3b_wb_cam #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_cam (
    .i_valid          (r_valid),
    .i_addr           (r_addr),
    .i_head           (r_head),
    .i_lookup_addr    (bus.lookup_addr),
    .o_lookup_hit     (w_lookup_hit),
    .o_lookup_idx     (w_lookup_idx),
    .i_coal_addr      (bus.evict_addr),
    .i_coal_mask_head (r_state == WB_WRITE),
    .o_coal_hit       (w_coal_hit),
    .o_coal_idx       (w_coal_idx)
  );

`ifdef LC3B_WB_COALESCE_EN
  assign w_coal_match = bus.evict_valid && w_coal_hit;
`else
  logic w_unused_coal;
  assign w_unused_coal = ^{w_coal_hit, w_coal_idx};
  assign w_coal_match  = 1'b0;
`endif

  assign w_full     = (r_count == FullCnt);
  assign w_ready    = !w_full || w_coal_match;
  assign w_push_acc = bus.evict_valid && w_ready;
  assign w_alloc    = w_push_acc && !w_coal_match;
  assign w_coal_wr  = w_push_acc && w_coal_match;
  assign w_pop      = (r_state == WB_WRITE) && bus.l2_resp;

  always_comb begin
    w_count_d = r_count;
    if (w_alloc && !w_pop) begin
      w_count_d = r_count + CW'(1);
    end else if (!w_alloc && w_pop) begin
      w_count_d = r_count - CW'(1);
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      WB_IDLE:  if (r_count != '0) w_state_d = WB_WRITE;
      WB_WRITE: if (w_pop && (w_count_d == '0)) w_state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_state <= WB_IDLE;
    end else begin
      r_state <= w_state_d;
      r_count <= w_count_d;
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
    end
  end

  // Payload array is qualified by r_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_addr[r_tail] <= bus.evict_addr;
      r_data[r_tail] <= bus.evict_data;
    end else if (w_coal_wr) begin
      r_data[w_coal_idx] <= bus.evict_data;
    end
  end

  assign bus.evict_ready = w_ready;
  assign bus.lookup_hit  = w_lookup_hit;
  assign bus.lookup_data = w_lookup_hit ? r_data[w_lookup_idx] : '0;
  assign bus.l2_write    = (r_state == WB_WRITE);
  assign bus.l2_addr     = (r_state == WB_WRITE) ? r_addr[r_head] : '0;
  assign bus.l2_wdata    = (r_state == WB_WRITE) ? r_data[r_head] : '0;
  assign bus.count       = r_count;
  assign bus.full        = w_full;
  assign bus.empty       = (r_count == '0);

endmodule

// File: doc/lc3b_wb_buffer.md
# lc3b_wb_buffer

Parametrised write-back buffer between the L1 data cache and L2. It absorbs dirty-line evictions from L1 into a DEPTH-entry FIFO, drains them to L2 one line at a time over a request/response handshake, and gives L1 a same-cycle address lookup so a miss on a line still in the buffer is served from the buffer instead of from stale L2 data. It generalises the single-line eviction register to configurable line width, address width and depth, and adds optional write coalescing.

## Interface
- LINE_W, 128: data bits per line; 128 for L1 lines, 256 for L2-width lines.
- ADDR_W, 12: line-address bits (byte address with the offset bits removed).
- DEPTH, 4: number of entries; power of two, minimum 2.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- evict_valid  in  1  L1 presents an eviction.
- evict_addr  in  ADDR_W  line address of the eviction.
- evict_data  in  LINE_W  line data.
- evict_ready  out  1  buffer can accept; equals !full.
- lookup_addr  in  ADDR_W  L1 miss address to probe.
- lookup_hit  out  1  combinational: a valid entry matches lookup_addr.
- lookup_data  out  LINE_W  combinational: data of the youngest matching entry; 0 when no hit.
- l2_write  out  1  registered write request to L2.
- l2_addr  out  ADDR_W  head entry address; 0 when l2_write is low.
- l2_wdata  out  LINE_W  head entry data; 0 when l2_write is low.
- l2_resp  in  1  one-cycle pulse from L2 completing the current write.
- count  out  $clog2(DEPTH+1)  occupied entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation
- Storage: DEPTH entries of {valid, addr, data}; circular head/tail pointers, $clog2(DEPTH) bits, wrap modulo DEPTH.
- Push: evict_valid && evict_ready allocates at tail, sets valid, increments tail and count.
- Full: evict_ready low; evict_valid is ignored even when a pop happens in the same cycle (no push-through when full).
- Drain FSM, two states:
  - WB_IDLE: l2_write=0. Go to WB_WRITE when count != 0.
  - WB_WRITE: l2_write=1; l2_addr/l2_wdata driven from the head entry and held stable until l2_resp. On l2_resp: clear head valid, advance head, decrement count; stay in WB_WRITE if count after the pop is nonzero, else go to WB_IDLE.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Lookup: compares lookup_addr against all valid entries; the head entry stays eligible while in flight. Multiple matches resolve to the youngest (closest to tail).
- l2_resp in WB_IDLE is ignored.

## Timing
- Reset (async assert): all valid bits 0, head=tail=0, count=0, FSM=WB_IDLE, l2_write=0, l2_addr=0, l2_wdata=0, evict_ready=1, empty=1, full=0, lookup_hit=0. Data array is not reset.
- Reset asserted mid-write drops all buffered lines; L2 must be reset with the same signal.
- Push-to-l2_write latency from empty: push at edge N, l2_write high after edge N+1.
- Back-to-back drain: next write presented the cycle after l2_resp, with no idle gap.
- A pushed entry is visible to lookup the cycle after its push edge. A popped entry is invisible the cycle after its l2_resp edge.

## Configuration
- LC3B_WB_COALESCE_EN defined: a push whose evict_addr matches a valid entry that is not the in-flight head (FSM in WB_WRITE) overwrites that entry's data in place. No allocation, and count and tail are unchanged. This is allowed when full, so evict_ready = !full || coalesce_match.
- Not defined: every push allocates a new entry; duplicates queue and drain in order, and lookup returns the youngest.

## Structure
- Shared package additions: line-address typedef lc3b_line_addr (ADDR_W default 12), and enum lc3b_wb_state {WB_IDLE, WB_WRITE}.
- One sub-module, lc3b_wb_cam: the per-entry address comparators and youngest-match priority select, parametrised on DEPTH/ADDR_W. It serves both lookup and the coalesce match; the coalesce port masks the head entry.

## Test plan
- Reset then single eviction addr=12'h0A3, data=128'hDEAD…: l2_write rises 2 edges later with l2_addr=12'h0A3; l2_resp pulse -> empty=1, l2_write=0 next cycle.
- Fill 4 entries (0x010..0x013) with l2_resp held off: full=1, evict_ready=0; a fifth evict_valid is dropped; 4 responses drain in order 0x010..0x013.
- Lookup: entries 0x020 and 0x030 queued, lookup_addr=0x030 -> hit, data of 0x030; lookup 0x040 -> hit=0, data=0.
- Simultaneous push 0x050 and l2_resp with count=2 -> count stays 2, next l2_addr is the second entry.
- Duplicate addr 0x060 pushed twice (data A then B), head is another line: with LC3B_WB_COALESCE_EN count=2 and L2 sees B once; without it count=3, lookup returns B, and L2 sees A then B.
- Async rst_n low during WB_WRITE with count=3 -> l2_write=0, count=0 immediately, before the next clk edge.
